maxpool_strategy1_ctrl: RTL and testbench
=========================================

// Module: maxpool_strategy1_ctrl
// PURPOSE
//  Sequencer for the 16-lane strategy-1 max-pooling datapath. Drives the datapath's shared
//  i_max_rst / i_maxpool controls and counts pooling-window elements from the PE array.
//  Presents each finished window's 16 maxima to the writeback stage with a valid/ready handshake.
//  Sits between the conv result stream and the maxpool datapath.
// PARAMETERS
//  WIN_W      4   width of window-size config; window holds 1..2**WIN_W-1 elements
//  CNT_W      16  width of window-count config / counter
// PORTS
//  i_clk          in   1      clock
//  i_rst_n        in   1      async active-low reset
//  i_start        in   1      start pulse; sampled only in IDLE
//  i_win_size     in   WIN_W  elements per window (e.g. 4 for 2x2); latched on start
//  i_num_win      in   CNT_W  windows per job; latched on start
//  i_res_valid    in   1      PE array result beat valid (all 16 lanes together)
//  o_res_ready    out  1      controller accepts a beat (ACCUM state)
//  o_max_rst      out  1      to datapath i_max_rst: clear all 16 max registers
//  o_maxpool      out  1      to datapath i_maxpool: compare/update on this beat
//  o_out_valid    out  1      16 datapath outputs hold a completed window max
//  i_out_ready    in   1      writeback accepts the window
//  o_busy         out  1      job in progress (state != IDLE)
//  o_done         out  1      one-cycle pulse after the last window is accepted
//  o_win_idx      out  CNT_W  index of the current window (0-based)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0; counters 0; latched config 0.
//  FSM states: IDLE, CLEAR, ACCUM, EMIT, DONE.
//   IDLE : i_start=1 -> latch cfg; if i_num_win==0 -> DONE, else -> CLEAR.
//   CLEAR: o_max_rst=1 for exactly 1 cycle; elem_cnt<=0 -> ACCUM.
//   ACCUM: o_res_ready=1; o_maxpool = i_res_valid (combinational, same-cycle as data);
//          each accepted beat increments elem_cnt; on the beat with elem_cnt==win_eff-1 -> EMIT.
//   EMIT : o_out_valid=1 and held until i_out_ready=1. Datapath outputs are stable here,
//          because o_maxpool=0 and o_max_rst=0.
//          On handshake: win_idx==num_win-1 -> DONE, else win_idx++ -> CLEAR.
//   DONE : o_done=1 for 1 cycle -> IDLE.
//  win_eff = (i_win_size==0) ? 1 : i_win_size (zero is treated as 1).
//  Latency: the last beat is accepted at edge N; o_out_valid is high in cycle N+1.
//   Minimum per window = 1 (CLEAR) + win_eff + 1 (EMIT) cycles.
//  Windows per job = num_win.
//  i_start while busy is ignored. Config changes mid-job are ignored (latched values are used).
//  i_res_valid outside ACCUM is not accepted (o_res_ready=0); the upstream must hold the beat.
//  win_idx counter wraps naturally, but it can never exceed num_win-1.
//  Async reset mid-job aborts immediately to IDLE. The datapath must then see o_max_rst before
//   the next window; CLEAR guarantees this.
//  o_max_rst and o_maxpool are mutually exclusive by construction.
// CONFIGURATION
//  MAXPOOL_CTRL_STALL_CNT_EN defined:
//   - adds output o_stall_cnt [31:0].
//   - counts cycles in ACCUM with i_res_valid=0 plus cycles in EMIT with i_out_ready=0.
//   - cleared on job start, saturates at 2**32-1, holds after DONE.
//  Not defined: the port is absent and there is no counter logic.
// STRUCTURE
//  Shared package maxpool_pkg:
//   - state encoding localparams (IDLE=0, CLEAR=1, ACCUM=2, EMIT=3, DONE=4; 3-bit)
//   - lane count constant MP_LANES=16
//   - result width constant MP_DW=32
//  One sub-module: maxpool_elem_cnt.
//   - ports: clr, inc, win_eff; outputs cnt and a last flag (cnt==win_eff-1 && inc).
//   - it is instantiated once in this controller.
//  The controller holds the FSM, win_idx and the config latches.
// TESTING
//  1 cfg win=4, num=1; start; valid high 4 cycles; ready=1 ->
//    o_max_rst 1 cycle, o_maxpool 4 cycles, o_out_valid 1 cycle, o_done 1 cycle, total 7 cycles to done.
//  2 win=4, num=3; valid continuous; i_out_ready held 0 for 5 cycles on window 1 ->
//    o_out_valid held 5+1 cycles, no o_maxpool during hold, o_win_idx 0,1,2, single o_done.
//  3 win=4; valid pattern 1,0,0,1,1,0,1 ->
//    o_maxpool pulses only on the 4 valid cycles, EMIT after the 7th cycle; datapath lane max = max of the 4 beats.
//  4 num=0 start -> DONE next cycle, o_done pulse, no o_max_rst/o_maxpool.
//    win=0, num=2 -> each window is 1 element.
//  5 start pulse during ACCUM with new cfg win=2 -> ignored; window still closes after 4 beats.
//  6 async reset asserted mid-ACCUM (beat 2 of 4) -> all outputs 0 immediately.
//    Restart -> o_max_rst precedes the first o_maxpool.
//    With MAXPOOL_CTRL_STALL_CNT_EN, test 2 gives o_stall_cnt=5.

Source files
------------

// File: rtl/maxpool_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_pkg
// Shared definitions for the strategy-1 max-pooling controller and its helpers.
//   MP_LANES  : number of datapath lanes driven together by one control pair
//   MP_DW     : width of one lane result
//   MP_ST_*   : sequencer state encodings (3 bits)
//   mp_state_e: enum built on the MP_ST_* encodings
//   mp_win_eff: maps a window-size setting to the effective element count
// -----------------------------------------------------------------------------
package maxpool_pkg;

  localparam int MP_LANES = 16;
  localparam int MP_DW    = 32;

  localparam logic [2:0] MP_ST_IDLE  = 3'd0;
  localparam logic [2:0] MP_ST_CLEAR = 3'd1;
  localparam logic [2:0] MP_ST_ACCUM = 3'd2;
  localparam logic [2:0] MP_ST_EMIT  = 3'd3;
  localparam logic [2:0] MP_ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    MP_IDLE  = MP_ST_IDLE,
    MP_CLEAR = MP_ST_CLEAR,
    MP_ACCUM = MP_ST_ACCUM,
    MP_EMIT  = MP_ST_EMIT,
    MP_DONE  = MP_ST_DONE
  } mp_state_e;

  // A window size of zero would never close; it is treated as one element.
  // Works on the 4-bit window-size field used by the controller.
  function automatic logic [3:0] mp_win_eff(input logic [3:0] win_size);
    mp_win_eff = (win_size == 4'd0) ? 4'd1 : win_size;
  endfunction

endpackage

// File: rtl/maxpool_elem_cnt.sv
// -----------------------------------------------------------------------------
// maxpool_elem_cnt
// Counts accepted elements inside one pooling window.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (start of a window)
//   inc        : one element accepted this cycle
//   win_eff    : elements per window (already mapped so it is never zero)
//   cnt        : elements accepted so far in this window
//   last       : this cycle's element completes the window (cnt==win_eff-1 && inc)
// -----------------------------------------------------------------------------
module maxpool_elem_cnt #(
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIN_W-1:0] win_eff,
  output logic [WIN_W-1:0] cnt,
  output logic             last
);

  localparam logic [WIN_W-1:0] ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + ONE;
    end
  end

  assign last = inc && (cnt == (win_eff - ONE));

endmodule

// File: rtl/maxpool_strategy1_ctrl.sv
// -----------------------------------------------------------------------------
// maxpool_strategy1_ctrl
// Sequencer for the 16-lane strategy-1 max-pooling datapath. It clears the
// shared max registers before each window, steers i_maxpool on every accepted
// result beat, and presents each finished window to writeback.
//
// Optional build macro: MAXPOOL_CTRL_STALL_CNT_EN adds o_stall_cnt, a 32-bit
// saturating count of cycles spent waiting on upstream (ACCUM, no valid beat)
// or downstream (EMIT, no ready). Cleared on job start, held after DONE.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Result beats: i_res_valid / o_res_ready (o_res_ready does not
// depend on i_res_valid; an un-accepted beat must be held by upstream). Window
// output: o_out_valid / i_out_ready (o_out_valid stays high, with stable data,
// until the transfer).
//
// Ports:
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_start          : job start pulse, sampled only in IDLE
//   i_win_size       : elements per window (0 treated as 1), latched on start
//   i_num_win        : windows per job, latched on start
//   i_res_valid      : PE array result beat valid
//   o_res_ready      : beat accepted when high (ACCUM)
//   o_max_rst        : clear datapath max registers (CLEAR)
//   o_maxpool        : datapath compare/update on this beat
//   o_out_valid      : window maxima available (EMIT)
//   i_out_ready      : writeback accepts the window
//   o_busy           : job in progress
//   o_done           : one-cycle pulse after the last window is taken
//   o_win_idx        : current window index (0-based)
//   o_state          : current sequencer state (debug)
//   o_elem_cnt       : elements accepted in the current window (debug)
//   o_stall_cnt      : stall cycle count (MAXPOOL_CTRL_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module maxpool_strategy1_ctrl
  import maxpool_pkg::*;
#(
  parameter int WIN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win_size,
  input  logic [CNT_W-1:0] i_num_win,
  input  logic             i_res_valid,
  output logic             o_res_ready,
  output logic             o_max_rst,
  output logic             o_maxpool,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_win_idx,
  output logic [2:0]       o_state,
  output logic [WIN_W-1:0] o_elem_cnt
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      o_stall_cnt
`endif
);

  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mp_state_e        state;
  logic [WIN_W-1:0] win_size_q;
  logic [CNT_W-1:0] num_win_q;
  logic [CNT_W-1:0] win_idx;
  logic [WIN_W-1:0] win_eff;
  logic [WIN_W-1:0] elem_cnt;
  logic             elem_last;
  logic             last_win;
  logic             start_job;

  assign win_eff   = (win_size_q == '0) ? WIN_ONE : win_size_q;
  assign last_win  = (win_idx == (num_win_q - CNT_ONE));
  assign start_job = (state == MP_IDLE) && i_start;

  // o_res_ready is only high in ACCUM and o_max_rst only in CLEAR, so the two
  // datapath controls can never be active together.
  assign o_maxpool = o_res_ready && i_res_valid;

  maxpool_elem_cnt #(
    .WIN_W (WIN_W)
  ) u_elem_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (o_max_rst),
    .inc     (o_maxpool),
    .win_eff (win_eff),
    .cnt     (elem_cnt),
    .last    (elem_last)
  );

  // Sequencer. Every output flag is registered and written together with the
  // state it belongs to, so each flag is a clean function of the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= MP_IDLE;
      win_size_q  <= '0;
      num_win_q   <= '0;
      win_idx     <= '0;
      o_res_ready <= 1'b0;
      o_max_rst   <= 1'b0;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      // Single-cycle flags default low.
      o_max_rst <= 1'b0;
      o_done    <= 1'b0;
      case (state)
        MP_IDLE: begin
          if (i_start) begin
            win_size_q <= i_win_size;
            num_win_q  <= i_num_win;
            win_idx    <= '0;
            o_busy     <= 1'b1;
            if (i_num_win == '0) begin
              state  <= MP_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= MP_CLEAR;
              o_max_rst <= 1'b1;
            end
          end
        end
        MP_CLEAR: begin
          state       <= MP_ACCUM;
          o_res_ready <= 1'b1;
        end
        MP_ACCUM: begin
          if (elem_last) begin
            state       <= MP_EMIT;
            o_res_ready <= 1'b0;
            o_out_valid <= 1'b1;
          end
        end
        MP_EMIT: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            if (last_win) begin
              state  <= MP_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= MP_CLEAR;
              o_max_rst <= 1'b1;
              win_idx   <= win_idx + CNT_ONE;
            end
          end
        end
        MP_DONE: begin
          state  <= MP_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state       <= MP_IDLE;
          o_res_ready <= 1'b0;
          o_out_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_win_idx  = win_idx;
  assign o_state    = state;
  assign o_elem_cnt = elem_cnt;

`ifdef MAXPOOL_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic        stall_hit;

  assign stall_hit = (o_res_ready && !i_res_valid) || (o_out_valid && !i_out_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (start_job) begin
      stall_cnt <= '0;
    end else if (stall_hit && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  // start_job only feeds the stall counter; keep it referenced in this build.
  logic unused_start_job;
  assign unused_start_job = start_job;
`endif

endmodule

// File: tb/tb_maxpool_strategy1_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maxpool_strategy1_ctrl
// Directed bench for the strategy-1 max-pooling sequencer: a table of
// full-job vectors plus hand-written sequences for back-pressure, gapped
// input, mid-job start and mid-job reset. A one-lane behavioural datapath
// follows o_max_rst/o_maxpool so window maxima can be checked.
// -----------------------------------------------------------------------------
module tb_maxpool_strategy1_ctrl;

  localparam int WIN_W = 4;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [WIN_W-1:0] i_win_size = '0;
  logic [CNT_W-1:0] i_num_win = '0;
  logic             i_res_valid = 1'b0;
  logic             i_out_ready = 1'b0;
  logic             o_res_ready, o_max_rst, o_maxpool, o_out_valid;
  logic             o_busy, o_done;
  logic [CNT_W-1:0] o_win_idx;
  logic [2:0]       o_state;
  logic [WIN_W-1:0] o_elem_cnt;
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
  logic [31:0]      o_stall_cnt;
`endif

  always #5 i_clk = ~i_clk;

  maxpool_strategy1_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_win_size  (i_win_size),
    .i_num_win   (i_num_win),
    .i_res_valid (i_res_valid),
    .o_res_ready (o_res_ready),
    .o_max_rst   (o_max_rst),
    .o_maxpool   (o_maxpool),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_win_idx   (o_win_idx),
    .o_state     (o_state),
    .o_elem_cnt  (o_elem_cnt)
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  // ---------------- one-lane reference datapath ----------------
  int res_data = 0;
  int dp_max = 0;
  always @(posedge i_clk) begin
    if (o_max_rst) dp_max <= 0;
    else if (o_maxpool && (res_data > dp_max)) dp_max <= res_data;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // per-job statistics
  int cyc, n_max_rst, n_maxpool, n_ov, n_done, n_excl, n_hold_mp, n_order;
  int first_mr, first_mp, first_ov, dp_at_emit, job_cycles;
  logic [63:0] mp_mask;
  logic        busy_after;
  logic [31:0] stall_after;
  int data_tab[16];

  task automatic clear_stats();
    n_max_rst = 0; n_maxpool = 0; n_ov = 0; n_done = 0; n_excl = 0;
    n_hold_mp = 0; n_order = 0; first_mr = -1; first_mp = -1; first_ov = -1;
    dp_at_emit = -1; mp_mask = '0;
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are sampled 1 ns later, so
  // combinational o_maxpool reflects the beat the next rising edge captures.
  task automatic tick(input logic st, input logic v, input logic r, input int d);
    @(negedge i_clk);
    i_start = st; i_res_valid = v; i_out_ready = r; res_data = d;
    #1;
    if (o_max_rst) begin
      n_max_rst++;
      if (first_mr < 0) first_mr = cyc;
    end
    if (o_maxpool) begin
      n_maxpool++;
      if (first_mp < 0) first_mp = cyc;
      if (cyc < 64) mp_mask[cyc] = 1'b1;
      if (n_max_rst == 0) n_order++;
    end
    if (o_max_rst && o_maxpool) n_excl++;
    if (o_out_valid) begin
      n_ov++;
      if (first_ov < 0) begin
        first_ov = cyc;
        dp_at_emit = dp_max;
      end
      if (o_maxpool) n_hold_mp++;
    end
    if (o_done) n_done++;
    if (o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL win_idx: unexpected window handshake, idx got %0d expected none", o_win_idx);
      end else begin
        check("win_idx", o_win_idx, exp_q.pop_front());
      end
    end
  endtask

  // Runs one job. vlen==0 means i_res_valid held high; otherwise vpat[k] is
  // the valid bit in cycle 2+k (first ACCUM cycle) and 0 elsewhere.
  // i_out_ready is low in cycles [rlo_from, rlo_from+rlo_len).
  // At cycle inj_cyc a new start with win=2, num=5 is presented.
  task automatic run_job(input int win, input int num, input logic [15:0] vpat,
                         input int vlen, input int rlo_from, input int rlo_len,
                         input int inj_cyc);
    logic st, v, r;
    int   d;
    bit   got_done;
    clear_stats();
    exp_q.delete();
    for (int k = 0; k < num; k++) exp_q.push_back(k[CNT_W-1:0]);
    i_win_size = win[WIN_W-1:0];
    i_num_win  = num[CNT_W-1:0];
    cyc = 0;
    tick(1'b1, (vlen == 0), 1'b1, 0);
    got_done = 0;
    while (!got_done && cyc < 200) begin
      cyc++;
      st = (cyc == inj_cyc);
      if (st) begin
        i_win_size = 4'd2;
        i_num_win  = 16'd5;
      end
      if (vlen == 0) v = 1'b1;
      else if (cyc >= 2 && cyc < 2 + vlen) v = vpat[cyc-2];
      else v = 1'b0;
      r = !(cyc >= rlo_from && cyc < rlo_from + rlo_len);
      d = (cyc < 16) ? data_tab[cyc] : 0;
      tick(st, v, r, d);
      if (o_done) got_done = 1;
    end
    job_cycles = got_done ? cyc : -1;
    cyc++;
    tick(1'b0, 1'b0, 1'b1, 0);
    busy_after = o_busy;
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    stall_after = o_stall_cnt;
`else
    stall_after = '0;
`endif
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int win;
    int num;
    int cycles;
    int mr;
    int mp;
    int ov;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    // cycles counts from the start edge to the o_done cycle:
    // num*(win_eff+2)+1 with continuous valid and ready; 1 when num==0.
    vecs[0] = '{win: 4,  num: 1, cycles: 7,  mr: 1, mp: 4,  ov: 1};
    vecs[1] = '{win: 4,  num: 3, cycles: 19, mr: 3, mp: 12, ov: 3};
    vecs[2] = '{win: 0,  num: 2, cycles: 7,  mr: 2, mp: 2,  ov: 2};
    vecs[3] = '{win: 1,  num: 1, cycles: 4,  mr: 1, mp: 1,  ov: 1};
    vecs[4] = '{win: 15, num: 2, cycles: 35, mr: 2, mp: 30, ov: 2};
    vecs[5] = '{win: 9,  num: 0, cycles: 1,  mr: 0, mp: 0,  ov: 0};
    vecs[6] = '{win: 2,  num: 4, cycles: 17, mr: 4, mp: 8,  ov: 4};
    for (int k = 0; k < 16; k++) data_tab[k] = 0;

    // ---- reset state ----
    i_res_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_flags", {o_res_ready, o_max_rst, o_maxpool, o_out_valid, o_busy, o_done}, 0);
    check("rst_state", o_state, 0);
    check("rst_win_idx", o_win_idx, 0);
    check("rst_elem_cnt", o_elem_cnt, 0);
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    check("rst_stall", o_stall_cnt, 0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_res_valid = 1'b0;
    cyc = 0;
    clear_stats();
    tick(1'b0, 1'b1, 1'b1, 0);
    check("idle_no_ready", {o_res_ready, o_maxpool, o_busy}, 0);

    // ---- table: continuous valid, ready always high ----
    foreach (vecs[i]) begin
      run_job(vecs[i].win, vecs[i].num, 16'h0, 0, 0, 0, -1);
      check($sformatf("v%0d_cycles", i), job_cycles, vecs[i].cycles);
      check($sformatf("v%0d_max_rst", i), n_max_rst, vecs[i].mr);
      check($sformatf("v%0d_maxpool", i), n_maxpool, vecs[i].mp);
      check($sformatf("v%0d_out_valid", i), n_ov, vecs[i].ov);
      check($sformatf("v%0d_done", i), n_done, 1);
      check($sformatf("v%0d_excl", i), n_excl, 0);
      check($sformatf("v%0d_busy_after", i), busy_after, 0);
    end

    // ---- back-pressure: window 1 held 5 cycles ----
    run_job(4, 3, 16'h0, 0, 12, 5, -1);
    check("bp_cycles", job_cycles, 24);
    check("bp_out_valid", n_ov, 8);
    check("bp_maxpool", n_maxpool, 12);
    check("bp_no_mp_hold", n_hold_mp, 0);
    check("bp_done", n_done, 1);
    check("bp_first_ov", first_ov, 6);
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    check("bp_stall", stall_after, 5);
`endif

    // ---- gapped input 1,0,0,1,1,0,1 with lane data ----
    data_tab[2] = 5;  data_tab[3] = 90; data_tab[4] = 80; data_tab[5] = 12;
    data_tab[6] = 30; data_tab[7] = 99; data_tab[8] = 7;
    run_job(4, 1, 16'h0059, 7, 0, 0, -1);
    check("gap_mp_mask", mp_mask, 64'h164);
    check("gap_first_ov", first_ov, 9);
    check("gap_cycles", job_cycles, 10);
    check("gap_lane_max", dp_at_emit, 30);
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    check("gap_stall", stall_after, 3);
`endif
    for (int k = 0; k < 16; k++) data_tab[k] = 0;

    // ---- start with new cfg during ACCUM is ignored ----
    run_job(4, 1, 16'h0, 0, 0, 0, 3);
    check("inj_cycles", job_cycles, 7);
    check("inj_maxpool", n_maxpool, 4);
    check("inj_max_rst", n_max_rst, 1);
    check("inj_done", n_done, 1);

    // ---- async reset mid-ACCUM (beat 2 of 4) ----
    clear_stats();
    exp_q.delete();
    i_win_size = 4'd4;
    i_num_win  = 16'd1;
    cyc = 0;
    tick(1'b1, 1'b1, 1'b1, 0);
    cyc = 1; tick(1'b0, 1'b1, 1'b1, 0);
    cyc = 2; tick(1'b0, 1'b1, 1'b1, 0);
    cyc = 3; tick(1'b0, 1'b1, 1'b1, 0);
    check("pre_rst_maxpool", o_maxpool, 1);
    i_rst_n = 1'b0;
    #1;
    check("arst_flags", {o_res_ready, o_max_rst, o_maxpool, o_out_valid, o_busy, o_done}, 0);
    check("arst_state", o_state, 0);
    check("arst_elem_cnt", o_elem_cnt, 0);
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
    check("arst_stall", o_stall_cnt, 0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_job(4, 1, 16'h0, 0, 0, 0, -1);
    check("rs_first_max_rst", first_mr, 1);
    check("rs_first_maxpool", first_mp, 2);
    check("rs_order", n_order, 0);
    check("rs_cycles", job_cycles, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
